rni_rr_arb_ptr: RTL and testbench
=================================

// Module: rni_rr_arb_ptr
// PURPOSE
//  Round-robin arbiter with a registered search pointer, successor to the combinational select-from-pointer helper.
//  Picks one of VEC_WIDTH masked requests, searching upward from the stored pointer with wrap-around.
//  Presents the winner on a valid/ready grant port, holds it stable while stalled, and supports optional lock (burst hold).
//  Used by RNI request/retry queues to pick the next entry fairly.
// PARAMETERS
//  VEC_WIDTH   4   number of requesters (>=2)
//  PTR_MODE    0   0: pointer moves to the bit after the accepted grant (fair); 1: pointer parks on the accepted grant (sticky)
//  LOCK_EN     1   1: lock input honoured; 0: lock ignored and the LOCK state is unreachable
// PORTS
//  clk         in   1                  clock
//  rst         in   1                  synchronous reset, active-high
//  req_vec     in   VEC_WIDTH          per-requester request
//  req_mask    in   VEC_WIDTH          1 = requester excluded from new arbitration
//  lock        in   1                  sampled on accept: keep the grant on the same requester
//  gnt_ready   in   1                  consumer accepts the grant this cycle
//  gnt_valid   out  1                  grant present
//  gnt_dec     out  VEC_WIDTH          one-hot grant (0 when !gnt_valid)
//  gnt_idx     out  $clog2(VEC_WIDTH)  encoded grant (0 when !gnt_valid)
//  ptr_dec     out  VEC_WIDTH          current one-hot search start pointer
// BEHAVIOUR
//  - One clock, synchronous active-high reset.
//  - Reset values: state=IDLE, ptr_dec=1 (bit 0), held index=0. gnt_valid=0 unless a request is present.
//  - Eligible set: elig = req_vec & ~req_mask.
//  - Arbitration (combinational, zero latency):
//    - Search elig from the ptr_dec bit inclusive, toward the MSB.
//    - If nothing is found, search from bit 0 to the bit below ptr_dec.
//    - First set bit wins.
//  - State machine {IDLE, HOLD, LOCK}:
//    - IDLE: grant = arbitration result; gnt_valid = |elig.
//    - HOLD: grant forced to the held index while req_vec[held]=1; the mask is ignored.
//      - If req_vec[held]=0: fall back to IDLE arbitration in the same cycle, and next state=IDLE unless the new grant stalls.
//    - LOCK: same forcing as HOLD, with the same req-drop fallback.
//  - Transitions, evaluated on the forced grant when one is in effect:
//    - valid & ~ready               -> HOLD; held <= gnt_idx.
//    - valid & ready & lock & LOCK_EN -> LOCK; held <= gnt_idx; ptr_dec unchanged.
//    - valid & ready & ~(lock & LOCK_EN) -> IDLE; pointer update.
//    - ~valid                       -> IDLE.
//  - Pointer update on a non-locking accept:
//    - PTR_MODE=0: ptr_dec <= gnt_dec rotated left by 1 (bit VEC_WIDTH-1 wraps to bit 0).
//    - PTR_MODE=1: ptr_dec <= gnt_dec.
//  - The pointer never changes on a stall, on a locked accept, or with no grant. ptr_dec is always one-hot.
//  - Simultaneous events:
//    - A mask rising on a held/locked requester does not break the hold.
//    - A request drop always breaks it.
//    - lock=1 with ready=0 has no effect; lock is sampled only on accept.
//  - Reset mid-hold/lock: next cycle state=IDLE, ptr_dec=1; the grant is re-arbitrated from bit 0.
//  - gnt_dec and gnt_idx are always consistent. Both are 0 when gnt_valid=0.
// TESTING (VEC_WIDTH=4, PTR_MODE=0, LOCK_EN=1 unless noted)
//  1 Reset, then req=4'b1111, ready=1 for 4 cycles -> gnt_idx 0,1,2,3; ptr_dec 0010,0100,1000,0001 (wrap).
//  2 ptr_dec=0100, req=4'b0011 -> gnt_idx=0 (wrap search). Accept -> ptr_dec=0010.
//  3 req=4'b1010, ready=0 for 3 cycles, then mask=4'b0010 and ready=1 -> gnt_idx=1 held throughout and accepted; ptr_dec=0100.
//  4 Accept idx2 with lock=1, req=4'b1111 -> idx2 granted 3 more cycles while lock=1; accept with lock=0 -> ptr_dec=1000; next grant idx3.
//  5 In LOCK on idx2, drop req[2] with req=4'b0011 -> same cycle grant idx0, state IDLE; PTR_MODE=1 accept of idx1 -> ptr_dec=0010 and idx1 wins again.
//  6 rst asserted while in HOLD on idx3 -> next cycle ptr_dec=0001, state IDLE; req=4'b1001 -> gnt_idx=0; req=0 -> gnt_valid=0, gnt_dec=0.

Source files
------------

// File: rtl/rni_rr_arb_ptr.sv
// rtl/rni_rr_arb_ptr.sv - round-robin arbiter with registered search pointer, stall hold and lock
module rni_rr_arb_ptr #(
  parameter int VEC_WIDTH = 4,
  parameter int PTR_MODE  = 0,
  parameter int LOCK_EN   = 1,
  localparam int IDX_W    = $clog2(VEC_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [VEC_WIDTH-1:0] req_vec,
  input  logic [VEC_WIDTH-1:0] req_mask,
  input  logic                 lock,
  input  logic                 gnt_ready,
  output logic                 gnt_valid,
  output logic [VEC_WIDTH-1:0] gnt_dec,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic [VEC_WIDTH-1:0] ptr_dec
);

  typedef enum logic [1:0] {IDLE, HOLD, LOCK} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     held_idx, held_nxt;
  logic [VEC_WIDTH-1:0] ptr_nxt;

  logic [VEC_WIDTH-1:0] elig, elig_hi, sel;
  logic [IDX_W-1:0]     arb_idx;
  logic                 forced;
  logic                 valid;
  logic [IDX_W-1:0]     idx;
  logic [VEC_WIDTH-1:0] dec;

  // Upper half of the search: eligible bits at or above the pointer; else wrap to the full set.
  always_comb begin
    elig    = req_vec & ~req_mask;
    elig_hi = elig & ~(ptr_dec - VEC_WIDTH'(1));
    sel     = (|elig_hi) ? elig_hi : elig;
    arb_idx = '0;
    for (int i = VEC_WIDTH - 1; i >= 0; i--) begin
      if (sel[i]) arb_idx = IDX_W'(i);
    end
  end

  // A held or locked requester keeps the grant only while it still requests; the mask is ignored.
  always_comb begin
    forced = (state != IDLE) && req_vec[held_idx];
    valid  = forced || (|elig);
    if (forced)     idx = held_idx;
    else if (valid) idx = arb_idx;
    else            idx = '0;
    dec = valid ? (VEC_WIDTH'(1) << idx) : '0;
  end

  always_comb begin
    state_nxt = IDLE;
    held_nxt  = held_idx;
    ptr_nxt   = ptr_dec;
    if (valid && !gnt_ready) begin
      state_nxt = HOLD;
      held_nxt  = idx;
    end else if (valid && lock && (LOCK_EN != 0)) begin
      state_nxt = LOCK;
      held_nxt  = idx;
    end else if (valid) begin
      ptr_nxt = (PTR_MODE == 0) ? {dec[VEC_WIDTH-2:0], dec[VEC_WIDTH-1]} : dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      held_idx <= '0;
      ptr_dec  <= VEC_WIDTH'(1);
    end else begin
      state    <= state_nxt;
      held_idx <= held_nxt;
      ptr_dec  <= ptr_nxt;
    end
  end

  assign gnt_valid = valid;
  assign gnt_idx   = idx;
  assign gnt_dec   = dec;

endmodule

// File: tb/tb_rni_rr_arb_ptr.sv
// tb/tb_rni_rr_arb_ptr.sv - directed and randomized checks of rni_rr_arb_ptr against a reference model
module tb_rni_rr_arb_ptr;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] req, mask;
  logic         lock, ready;

  logic         v0, v1;
  logic [W-1:0] dec0, dec1, pd0, pd1;
  logic [1:0]   idx0, idx1;

  int checks = 0;
  int failures = 0;

  // reference state per instance: pointer as an integer, held requester (-1 = none)
  int mptr[2];
  int mheld[2];
  int mg[2];

  always #5 clk = ~clk;

  rni_rr_arb_ptr #(.VEC_WIDTH(W), .PTR_MODE(0), .LOCK_EN(1)) dut0 (
    .clk(clk), .rst(rst), .req_vec(req), .req_mask(mask), .lock(lock), .gnt_ready(ready),
    .gnt_valid(v0), .gnt_dec(dec0), .gnt_idx(idx0), .ptr_dec(pd0));

  rni_rr_arb_ptr #(.VEC_WIDTH(W), .PTR_MODE(1), .LOCK_EN(1)) dut1 (
    .clk(clk), .rst(rst), .req_vec(req), .req_mask(mask), .lock(lock), .gnt_ready(ready),
    .gnt_valid(v1), .gnt_dec(dec1), .gnt_idx(idx1), .ptr_dec(pd1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_pick(int ptr, int held, logic [W-1:0] rq, logic [W-1:0] mk);
    int j;
    if (held >= 0 && rq[held]) return held;
    for (int k = 0; k < W; k++) begin
      j = (ptr + k) % W;
      if (rq[j] && !mk[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mptr[m]  = 0;
      mheld[m] = -1;
    end
  endtask

  task automatic check_one(input string tag, input int g, input int ptr, input logic v,
                           input logic [1:0] ix, input logic [W-1:0] dc, input logic [W-1:0] pd);
    logic [W-1:0] edec;
    edec = (g >= 0) ? W'(1 << g) : '0;
    chk({tag, "_valid"}, 32'(v), 32'(g >= 0));
    chk({tag, "_idx"}, 32'(ix), (g >= 0) ? 32'(g) : 32'd0);
    chk({tag, "_dec"}, 32'(dc), 32'(edec));
    chk({tag, "_ptr"}, 32'(pd), 32'(1 << ptr));
  endtask

  // apply inputs, settle, compare both instances with the model
  task automatic drive(input logic r, input logic [W-1:0] rq, input logic [W-1:0] mk,
                       input logic lk, input logic rd);
    rst = r; req = rq; mask = mk; lock = lk; ready = rd;
    #1;
    for (int m = 0; m < 2; m++) mg[m] = ref_pick(mptr[m], mheld[m], req, mask);
    check_one("m0", mg[0], mptr[0], v0, idx0, dec0, pd0);
    check_one("m1", mg[1], mptr[1], v1, idx1, dec1, pd1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      for (int m = 0; m < 2; m++) begin
        if (mg[m] < 0) mheld[m] = -1;
        else if (!ready || lock) mheld[m] = mg[m];
        else begin
          mheld[m] = -1;
          mptr[m]  = (m == 0) ? (mg[m] + 1) % W : mg[m];
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req = '0; mask = '0; lock = 1'b0; ready = 1'b0;
    @(negedge clk);
    @(posedge clk);
    model_reset();
    @(negedge clk);

    // reset state with no requests
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    chk("reset_ptr", 32'(pd0), 32'h1);
    chk("reset_valid", 32'(v0), 32'h0);
    tick();

    // rotation through all four and wrap
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1);
      chk("rot_idx", 32'(idx0), 32'(i));
      tick();
    end
    chk("rot_wrap_ptr", 32'(pd0), 32'h1);

    // wrap-around search from ptr=0100
    drive(1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1);
    tick();
    drive(1'b0, 4'b0011, 4'b0000, 1'b0, 1'b1);
    chk("wrap_idx", 32'(idx0), 32'h0);
    tick();
    chk("wrap_ptr", 32'(pd0), 32'h2);

    // stall hold, then mask rising on held requester does not break it
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1010, 4'b0000, 1'b0, 1'b0);
      chk("hold_idx", 32'(idx0), 32'h1);
      tick();
    end
    drive(1'b0, 4'b1010, 4'b0010, 1'b0, 1'b1);
    chk("hold_mask_idx", 32'(idx0), 32'h1);
    tick();
    chk("hold_ptr", 32'(pd0), 32'h4);

    // lock burst on idx2
    drive(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1);
    chk("lock_first", 32'(idx0), 32'h2);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1);
      chk("lock_idx", 32'(idx0), 32'h2);
      chk("lock_ptr", 32'(pd0), 32'h4);
      tick();
    end
    drive(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1);
    tick();
    chk("unlock_ptr", 32'(pd0), 32'h8);
    drive(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0);
    chk("unlock_next", 32'(idx0), 32'h3);
    tick();

    // reset while holding idx3
    drive(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'b1001, 4'b0000, 1'b0, 1'b0);
    chk("rst_hold_ptr", 32'(pd0), 32'h1);
    chk("rst_hold_idx", 32'(idx0), 32'h0);
    tick();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    chk("idle_valid", 32'(v0), 32'h0);
    chk("idle_dec", 32'(dec0), 32'h0);
    tick();

    // request drop in LOCK falls back to arbitration in the same cycle
    drive(1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1);
    tick();
    drive(1'b0, 4'b0011, 4'b0000, 1'b0, 1'b1);
    chk("drop_idx", 32'(idx0), 32'h0);
    tick();
    // sticky pointer mode parks on the winner
    drive(1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1);
    tick();
    chk("sticky_ptr", 32'(pd1), 32'h2);
    drive(1'b0, 4'b0011, 4'b0000, 1'b0, 1'b1);
    chk("sticky_idx", 32'(idx1), 32'h1);
    tick();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) == 0), W'($urandom), W'($urandom & $urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
